reg_dump_unit: RTL and testbench
================================

Name: reg_dump_unit

Overview:
End-of-run observer for the cpu core. It counts clocks from reset until the core raises completed, or until a timeout. It then snapshots the 32 architectural registers exposed by the core and streams the cycle count and the register values out over a valid/ready word stream. That stream feeds the UART or host-dump path, so every run can be checked off-simulator.

Parameters:
XLEN, 32, width of each register and of each stream data word
MAX_CLOCKS, 100000, clock budget; the timeout fires when the count reaches this value without completed; must be >= 1 and < 2^32
NREGS, 32, number of registers captured (fixed at 32 for the core; the parameter exists only for the bench)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
completed  input  1  core halt flag, level
registers  input  [XLEN-1:0] x [0:NREGS-1]  unpacked register array driven by the core
out_valid  output  1  stream word valid
out_ready  input  1  downstream accepts the word
out_data  output  XLEN  stream word
out_index  output  6  word number, 0..NREGS
out_last  output  1  high on the final word (index NREGS)
timed_out  output  1  run ended by timeout instead of completed
done  output  1  dump finished, sticky

Behaviour:
- Single clock domain: clk. Reset is asynchronous, active-high, on rst.
- Reset values:
  - state = RUN, cycle_count = 0, idx = 0.
  - out_valid = 0, out_data = 0, out_index = 0, out_last = 0.
  - timed_out = 0, done = 0.
  - Snapshot buffer contents are don't-care.
- State RUN, at each rising edge:
  - If completed = 1: capture registers[0..NREGS-1] into the snapshot buffer, hold cycle_count, timed_out <= 0, go to SEND.
  - Else if cycle_count == MAX_CLOCKS-1: cycle_count <= MAX_CLOCKS, capture the snapshot, timed_out <= 1, go to SEND.
  - Else: cycle_count <= cycle_count + 1.
  - completed has priority when both conditions hold on the same edge.
- cycle_count meaning: the number of RUN edges before the triggering edge. If completed is already high at the first edge after reset, the count is 0.
- Snapshot: taken only on the trigger edge. Later changes on registers or completed are ignored until the next reset.
- State SEND: out_valid = 1 from the cycle after the trigger edge.
  - Word 0: out_data = cycle_count.
  - Word k (1..NREGS): out_data = snapshot[k-1].
  - out_index = idx, out_last = (idx == NREGS).
  - Outputs are registered and held stable while out_valid && !out_ready.
- Transfer occurs on an edge with out_valid && out_ready.
  - If idx < NREGS: idx + 1, and the next word is presented in the next cycle with no bubble.
  - If idx == NREGS: go to DONE; out_valid, out_last and out_index drop to 0 on that edge.
- Sustained throughput: one word per clock while out_ready = 1. The full dump takes NREGS+1 = 33 transfer cycles.
- out_ready is ignored outside SEND. out_valid never depends combinationally on out_ready.
- State DONE: done = 1, out_valid = 0. timed_out and cycle_count are retained. The block stays here until reset.
- Reset asserted mid-SEND: outputs go to their reset values immediately (asynchronously). The in-flight word is abandoned and the dump restarts only after the next trigger.

Test Plan:
- completed rises at edge 6 after reset release, registers[i] = i*3, out_ready tied 1:
  - 33 words on consecutive cycles: word0 = 5, word k = 3*(k-1).
  - out_last only on index 32, then done = 1, timed_out = 0.
- Backpressure: out_ready toggles 1,0,0,1,... during the same run:
  - out_data and out_index are stable across every stall, no word is dropped or duplicated.
  - Total transfers = 33.
- MAX_CLOCKS = 16, completed held 0:
  - Trigger on the 16th edge, word0 = 16, timed_out = 1, dump completes, done = 1.
- MAX_CLOCKS = 16, completed rises on the 16th edge:
  - completed wins: word0 = 15, timed_out = 0.
- registers all overwritten with 32'hDEADBEEF one cycle after the trigger:
  - The streamed values are the pre-trigger snapshot; none equal DEADBEEF.
  - completed dropping to 0 during SEND has no effect.
- rst pulsed while out_index = 10:
  - out_valid = 0 and done = 0 immediately; cycle_count restarts at 0.
  - A fresh completed produces a full 33-word dump.

Source files
------------

// File: rtl/reg_dump_unit.sv
// End-of-run observer: counts clocks until the core completes or times out, snapshots
// the register file, then streams {cycle_count, regs[0..NREGS-1]} over valid/ready.
module reg_dump_unit #(
    parameter int XLEN       = 32,
    parameter int MAX_CLOCKS = 100000,
    parameter int NREGS      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            completed,
    input  logic [XLEN-1:0] registers [0:NREGS-1],
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [5:0]      out_index,
    output logic            out_last,
    output logic            timed_out,
    output logic            done
);

    localparam int          IDXW     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [31:0] LAST_CNT = 32'(MAX_CLOCKS - 1);
    localparam logic [31:0] MAX_CNT  = 32'(MAX_CLOCKS);
    localparam logic [5:0]  LAST_IDX = 6'(NREGS);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SEND,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       count_q, count_d;
    logic [5:0]        idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              last_q, last_d;
    logic              timed_q, timed_d;
    logic              done_q, done_d;
    logic              capture;
    logic [XLEN-1:0]   snap_q [0:NREGS-1];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        timed_d = timed_q;
        done_d  = done_q;
        capture = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (completed) begin
                    capture = 1'b1;
                    timed_d = 1'b0;
                    data_d  = XLEN'(count_q);
                end else if (count_q == LAST_CNT) begin
                    capture = 1'b1;
                    count_d = MAX_CNT;
                    timed_d = 1'b1;
                    data_d  = XLEN'(MAX_CNT);
                end else begin
                    count_d = count_q + 32'd1;
                end
                if (capture) begin
                    state_d = ST_SEND;
                    valid_d = 1'b1;
                    idx_d   = 6'd0;
                    last_d  = 1'b0;
                end
            end

            ST_SEND: begin
                if (valid_q && out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = 6'd0;
                        done_d  = 1'b1;
                    end else begin
                        // Word k carries snapshot[k-1], so the word after idx is snapshot[idx].
                        idx_d  = idx_q + 6'd1;
                        data_d = snap_q[idx_q[IDXW-1:0]];
                        last_d = ((idx_q + 6'd1) == LAST_IDX);
                    end
                end
            end

            ST_DONE: begin
                done_d = 1'b1;
            end

            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            count_q <= 32'd0;
            idx_q   <= 6'd0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            timed_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            timed_q <= timed_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the snapshot is deliberately not reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (capture) begin
            snap_q <= registers;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = idx_q;
    assign out_last  = last_q;
    assign timed_out = timed_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: a word-list scoreboard checked every cycle,
// plus literal expectations per scenario.
module tb_reg_dump_unit;

    localparam int MAXC = 16;
    localparam int NR   = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        completed;
    logic [31:0] regs [0:NR-1];
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_index;
    logic        out_last;
    logic        timed_out;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Scoreboard: phase 0 = counting, 1 = streaming, 2 = finished.
    int          phase = 0;
    int          m_edges = 0;
    int          m_ptr = 0;
    logic        m_timed = 1'b0;
    logic [31:0] exp_words [0:NR];
    logic [31:0] got [$];

    reg_dump_unit #(.XLEN(32), .MAX_CLOCKS(MAXC), .NREGS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .completed (completed),
        .registers (regs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .timed_out (timed_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic capture(input logic [31:0] w0, input logic t);
        exp_words[0] = w0;
        for (int k = 1; k <= NR; k++) exp_words[k] = regs[k-1];
        m_timed = t;
        m_ptr   = 0;
        phase   = 1;
    endtask

    // Runs mid-cycle: checks current outputs, then predicts the next rising edge.
    task automatic model_step();
        if (rst) begin
            phase = 0; m_edges = 0; m_ptr = 0; got.delete();
            check("rst_valid", out_valid, 0);
            check("rst_data",  out_data, 0);
            check("rst_index", out_index, 0);
            check("rst_last",  out_last, 0);
            check("rst_timed", timed_out, 0);
            check("rst_done",  done, 0);
        end else begin
            case (phase)
                0: begin
                    check("run_valid", out_valid, 0);
                    check("run_done", done, 0);
                    if (completed) capture(32'(m_edges), 1'b0);
                    else if (m_edges == MAXC - 1) capture(32'(MAXC), 1'b1);
                    else m_edges++;
                end
                1: begin
                    check("send_valid", out_valid, 1);
                    check("send_index", out_index, 64'(m_ptr));
                    check("send_data",  out_data, exp_words[m_ptr]);
                    check("send_last",  out_last, (m_ptr == NR));
                    check("send_timed", timed_out, m_timed);
                    check("send_done",  done, 0);
                    if (out_ready) begin
                        got.push_back(out_data);
                        if (m_ptr == NR) phase = 2;
                        else m_ptr++;
                    end
                end
                default: begin
                    check("done_valid", out_valid, 0);
                    check("done_flag",  done, 1);
                    check("done_index", out_index, 0);
                    check("done_last",  out_last, 0);
                    check("done_timed", timed_out, m_timed);
                end
            endcase
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic apply_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        completed = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b0;
    endtask

    // completed is first sampled high on rising edge n after reset release.
    task automatic start_run(input int n);
        apply_reset();
        repeat (n - 1) @(posedge clk);
        #2 completed = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        check("done_reached", done, 1);
    endtask

    initial begin
        int nbad;
        rst = 1'b1; completed = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < NR; i++) regs[i] = 32'd0;
        #3;
        check("init_valid", out_valid, 0);
        check("init_done", done, 0);

        // Normal completion, no backpressure.
        for (int i = 0; i < NR; i++) regs[i] = 32'(i * 3);
        out_ready = 1'b1;
        start_run(6);
        wait_done(100);
        check("t1_count", got.size(), 33);
        check("t1_word0", got[0], 5);
        check("t1_word1", got[1], 0);
        check("t1_word32", got[32], 93);
        check("t1_timed", timed_out, 0);

        // Backpressure pattern 1,0,0 repeating.
        out_ready = 1'b0;
        start_run(6);
        for (int c = 0; c < 300 && !done; c++) begin
            out_ready = (c % 3 == 0);
            @(posedge clk); #2;
        end
        check("t2_done", done, 1);
        check("t2_count", got.size(), 33);
        check("t2_word0", got[0], 5);
        check("t2_word20", got[20], 57);

        // Timeout with completed held low.
        for (int i = 0; i < NR; i++) regs[i] = 32'(i + 100);
        out_ready = 1'b1;
        apply_reset();
        wait_done(100);
        check("t3_count", got.size(), 33);
        check("t3_word0", got[0], 16);
        check("t3_word5", got[5], 104);
        check("t3_timed", timed_out, 1);

        // completed on the same edge the timeout would fire: completed wins.
        start_run(16);
        wait_done(100);
        check("t4_word0", got[0], 15);
        check("t4_timed", timed_out, 0);

        // Registers and completed change after the trigger.
        for (int i = 0; i < NR; i++) regs[i] = 32'(i * 7);
        start_run(3);
        @(posedge clk); #2;
        for (int i = 0; i < NR; i++) regs[i] = 32'hDEADBEEF;
        completed = 1'b0;
        wait_done(100);
        nbad = 0;
        foreach (got[i]) if (got[i] == 32'hDEADBEEF) nbad++;
        check("t5_count", got.size(), 33);
        check("t5_no_overwrite", nbad, 0);
        check("t5_word0", got[0], 2);
        check("t5_word32", got[32], 217);

        // Reset in the middle of the dump.
        for (int i = 0; i < NR; i++) regs[i] = 32'(i * 3);
        start_run(6);
        for (int c = 0; c < 60 && !(out_valid && out_index == 6'd10); c++) begin
            @(posedge clk); #2;
        end
        check("t6_at_idx10", out_index, 10);
        rst = 1'b1;
        completed = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_done", done, 0);
        check("t6_async_index", out_index, 0);
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 completed = 1'b1;
        wait_done(100);
        check("t6_count", got.size(), 33);
        check("t6_word0", got[0], 3);
        check("t6_word32", got[32], 93);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
